// File: rtl/divclk_monitor.sv
// Fast-domain monitor for a divided clock: synchronizes div_in, emits edge strobes,
// measures half-periods and tracks lock. Optional err_cnt output via DIVMON_ERRCNT_EN.
module divclk_monitor #(
  parameter int unsigned HALF_PERIOD = 16,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             level,
  output logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] meas_hp,
  output logic             locked,
  output logic             err_stb
`ifdef DIVMON_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int unsigned STALL_AT = 2 * HALF_PERIOD;
  localparam int unsigned GC_W     = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] PHASE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [GC_W-1:0]        r_good_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_stall_done;

  logic                   w_level;
  logic                   w_edge;
  logic [CNT_W-1:0]       w_phase_inc;
  logic [31:0]            w_meas_ext;
  logic                   w_good;
  logic                   w_stall;
  logic                   w_lock_reached;

  // Synchronizer chain; resets high to match the divider's initial level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], div_in};
    end
  end

  assign w_level     = r_sync[SYNC_STAGES-1];
  assign level       = w_level;
  assign w_edge      = w_level ^ r_prev;
  // Saturating phase+1 doubles as the measurement loaded on an edge.
  assign w_phase_inc = (phase == PHASE_MAX) ? phase : phase + CNT_W'(1);
  assign w_meas_ext  = 32'(w_phase_inc);
  assign w_good      = ((w_meas_ext + TOL) >= HALF_PERIOD) && (w_meas_ext <= (HALF_PERIOD + TOL));
  assign w_stall     = !w_edge && !r_stall_done && (w_meas_ext == STALL_AT);
  assign w_lock_reached = ((32'(r_good_cnt) + 32'd1) >= LOCK_COUNT);

  // Lock FSM with strobes, phase/measurement counters and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_good_cnt   <= '0;
      r_prev       <= 1'b1;
      r_stall_done <= 1'b0;
      rise_stb     <= 1'b0;
      fall_stb     <= 1'b0;
      phase        <= '0;
      meas_hp      <= '0;
      locked       <= 1'b0;
      err_stb      <= 1'b0;
    end else begin
      r_prev   <= w_level;
      rise_stb <= w_edge & w_level;
      fall_stb <= w_edge & ~w_level;
      err_stb  <= 1'b0;
      locked   <= (r_state == S_LOCKED);

      if (w_edge) begin
        phase        <= '0;
        meas_hp      <= w_phase_inc;
        r_stall_done <= 1'b0;
      end else begin
        phase <= w_phase_inc;
        if (w_stall) begin
          r_stall_done <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          // First edge only establishes a reference; its measurement is not judged.
          if (w_edge) begin
            r_state    <= S_ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        S_ACQUIRE: begin
          if (w_edge) begin
            if (w_good) begin
              if (w_lock_reached) begin
                r_state    <= S_LOCKED;
                r_good_cnt <= GC_W'(LOCK_COUNT);
              end else begin
                r_good_cnt <= r_good_cnt + GC_W'(1);
              end
            end else begin
              r_good_cnt <= '0;
              err_stb    <= 1'b1;
            end
          end else if (w_stall) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
            err_stb    <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_edge) begin
            if (!w_good) begin
              r_state    <= S_ACQUIRE;
              r_good_cnt <= '0;
              err_stb    <= 1'b1;
            end
          end else if (w_stall) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
            err_stb    <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_good_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DIVMON_ERRCNT_EN
  // Saturating count of error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_stb && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_divclk_monitor.sv
// Directed bench for divclk_monitor: strobe latency, lock acquisition, bad half-period,
// stall, async reset and (with DIVMON_ERRCNT_EN) the error counter.
module tb_divclk_monitor;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_in;
  logic             rise_stb;
  logic             fall_stb;
  logic             level;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] meas_hp;
  logic             locked;
  logic             err_stb;
`ifdef DIVMON_ERRCNT_EN
  logic [15:0]      err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  divclk_monitor #(
    .HALF_PERIOD(16), .TOL(1), .LOCK_COUNT(4), .CNT_W(CNT_W), .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div_in),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .level   (level),
    .phase   (phase),
    .meas_hp (meas_hp),
    .locked  (locked),
    .err_stb (err_stb)
`ifdef DIVMON_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Event log sampled on the falling edge, away from the active edge.
  int cyc = 0;
  int stb_cyc[$];
  bit stb_rise[$];
  int stb_meas[$];
  int err_cyc[$];
  int err_phase[$];
  int lock_rise = -1;
  int lock_fall = -1;
  logic prev_locked = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rise_stb || fall_stb) begin
      stb_cyc.push_back(cyc);
      stb_rise.push_back(rise_stb);
      stb_meas.push_back(int'(meas_hp));
    end
    if (err_stb) begin
      err_cyc.push_back(cyc);
      err_phase.push_back(int'(phase));
    end
    if (locked && !prev_locked) lock_rise = cyc;
    if (!locked && prev_locked) lock_fall = cyc;
    prev_locked = locked;
  end

  task automatic clear_log();
    stb_cyc.delete();
    stb_rise.delete();
    stb_meas.delete();
    err_cyc.delete();
    err_phase.delete();
    lock_rise = -1;
    lock_fall = -1;
  endtask

  task automatic drive(input int n, input logic v);
    div_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    div_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_in = 1'b1;
    #2;
    checks++; if (rise_stb !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", rise_stb); end
    checks++; if (fall_stb !== 1'b0) begin failures++; $display("FAIL reset_fall got=%b exp=0", fall_stb); end
    checks++; if (level !== 1'b1) begin failures++; $display("FAIL reset_level got=%b exp=1", level); end
    checks++; if (phase !== 8'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (meas_hp !== 8'd0) begin failures++; $display("FAIL reset_meas got=%0d exp=0", meas_hp); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err_stb !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_stb); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Ideal 16/16 toggle from reset: latency, spacing, measurement and lock point.
  task automatic test_ideal();
    bit exp;
    clear_log();
    div_in = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        exp = (k == 3);
        checks++;
        if (fall_stb !== exp) begin failures++; $display("FAIL ideal_latency k=%0d got=%b exp=%b", k, fall_stb, exp); end
      end
    end
    drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1);
    checks++;
    if (stb_cyc.size() != 6) begin
      failures++; $display("FAIL ideal_stb_count got=%0d exp=6", stb_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (stb_rise[i] != bit'(i % 2)) begin failures++; $display("FAIL ideal_polarity i=%0d got=%b exp=%b", i, stb_rise[i], bit'(i % 2)); end
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (stb_cyc[i] - stb_cyc[i-1] != 16) begin failures++; $display("FAIL ideal_gap i=%0d got=%0d exp=16", i, stb_cyc[i] - stb_cyc[i-1]); end
        checks++;
        if (stb_meas[i] != 16) begin failures++; $display("FAIL ideal_meas i=%0d got=%0d exp=16", i, stb_meas[i]); end
      end
      checks++;
      if (lock_rise != stb_cyc[4] + 1) begin failures++; $display("FAIL ideal_lock_time got=%0d exp=%0d", lock_rise, stb_cyc[4] + 1); end
    end
    checks++;
    if (err_cyc.size() != 0) begin failures++; $display("FAIL ideal_no_err got=%0d exp=0", err_cyc.size()); end
  endtask

  // One 19-cycle half-period while locked, then recovery.
  task automatic test_bad_half();
    clear_log();
    drive(19, 1'b0); drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1);
    checks++;
    if (stb_cyc.size() != 6) begin
      failures++; $display("FAIL bad_stb_count got=%0d exp=6", stb_cyc.size());
    end else begin
      checks++; if (stb_meas[0] != 16) begin failures++; $display("FAIL bad_meas0 got=%0d exp=16", stb_meas[0]); end
      checks++; if (stb_meas[1] != 19) begin failures++; $display("FAIL bad_meas1 got=%0d exp=19", stb_meas[1]); end
      checks++;
      if (err_cyc.size() != 1) begin
        failures++; $display("FAIL bad_err_count got=%0d exp=1", err_cyc.size());
      end else begin
        checks++; if (err_cyc[0] != stb_cyc[1]) begin failures++; $display("FAIL bad_err_time got=%0d exp=%0d", err_cyc[0], stb_cyc[1]); end
      end
      checks++; if (lock_fall != stb_cyc[1] + 1) begin failures++; $display("FAIL bad_unlock_time got=%0d exp=%0d", lock_fall, stb_cyc[1] + 1); end
      checks++; if (lock_rise != stb_cyc[5] + 1) begin failures++; $display("FAIL bad_relock_time got=%0d exp=%0d", lock_rise, stb_cyc[5] + 1); end
    end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL bad_locked_end got=%b exp=1", locked); end
  endtask

  // div_in frozen while locked: one stall error at phase 32, then saturation.
  task automatic test_stall();
    clear_log();
    drive(300, 1'b1);
    checks++;
    if (err_cyc.size() != 1) begin
      failures++; $display("FAIL stall_err_count got=%0d exp=1", err_cyc.size());
    end else begin
      checks++; if (err_phase[0] != 32) begin failures++; $display("FAIL stall_err_phase got=%0d exp=32", err_phase[0]); end
      checks++; if (lock_fall != err_cyc[0] + 1) begin failures++; $display("FAIL stall_unlock_time got=%0d exp=%0d", lock_fall, err_cyc[0] + 1); end
    end
    checks++; if (stb_cyc.size() != 0) begin failures++; $display("FAIL stall_no_stb got=%0d exp=0", stb_cyc.size()); end
    checks++; if (phase !== 8'd255) begin failures++; $display("FAIL stall_phase_sat got=%0d exp=255", phase); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL stall_locked got=%b exp=0", locked); end
  endtask

  // Alternating 17/15 half-periods are within tolerance and still lock.
  task automatic test_jitter();
    do_reset();
    clear_log();
    drive(17, 1'b0); drive(15, 1'b1); drive(17, 1'b0); drive(15, 1'b1); drive(17, 1'b0); drive(15, 1'b1);
    checks++;
    if (stb_cyc.size() != 6) begin
      failures++; $display("FAIL jitter_stb_count got=%0d exp=6", stb_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (stb_meas[i] != ((i % 2 == 1) ? 17 : 15)) begin
          failures++; $display("FAIL jitter_meas i=%0d got=%0d exp=%0d", i, stb_meas[i], (i % 2 == 1) ? 17 : 15);
        end
      end
      checks++; if (lock_rise != stb_cyc[4] + 1) begin failures++; $display("FAIL jitter_lock_time got=%0d exp=%0d", lock_rise, stb_cyc[4] + 1); end
    end
    checks++; if (err_cyc.size() != 0) begin failures++; $display("FAIL jitter_no_err got=%0d exp=0", err_cyc.size()); end
  endtask

  // Async reset mid-lock with div_in high, then a full reacquisition.
  task automatic test_reset_mid_lock();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rml_pre_locked got=%b exp=1", locked); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rml_locked got=%b exp=0", locked); end
    checks++; if (phase !== 8'd0) begin failures++; $display("FAIL rml_phase got=%0d exp=0", phase); end
    checks++; if (meas_hp !== 8'd0) begin failures++; $display("FAIL rml_meas got=%0d exp=0", meas_hp); end
    checks++; if (level !== 1'b1) begin failures++; $display("FAIL rml_level got=%b exp=1", level); end
    checks++; if ({rise_stb, fall_stb, err_stb} !== 3'b000) begin failures++; $display("FAIL rml_strobes got=%b exp=000", {rise_stb, fall_stb, err_stb}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    drive(40, 1'b1);
    checks++; if (stb_cyc.size() != 0) begin failures++; $display("FAIL rml_false_stb got=%0d exp=0", stb_cyc.size()); end
    checks++; if (err_cyc.size() != 0) begin failures++; $display("FAIL rml_idle_err got=%0d exp=0", err_cyc.size()); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rml_locked_idle got=%b exp=0", locked); end
    clear_log();
    drive(16, 1'b0); drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1); drive(16, 1'b0); drive(16, 1'b1);
    checks++;
    if (stb_cyc.size() != 6) begin
      failures++; $display("FAIL rml_stb_count got=%0d exp=6", stb_cyc.size());
    end else begin
      checks++; if (lock_rise != stb_cyc[4] + 1) begin failures++; $display("FAIL rml_relock_time got=%0d exp=%0d", lock_rise, stb_cyc[4] + 1); end
    end
  endtask

`ifdef DIVMON_ERRCNT_EN
  task automatic test_err_cnt();
    do_reset();
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL errcnt_reset got=%0d exp=0", err_cnt); end
    drive(16, 1'b0); drive(16, 1'b1); drive(10, 1'b0); drive(10, 1'b1); drive(10, 1'b0); drive(16, 1'b1);
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL errcnt_three got=%0d exp=3", err_cnt); end
    force dut.err_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt;
    drive(10, 1'b0); drive(16, 1'b1);
    checks++; if (err_cnt !== 16'hFFFF) begin failures++; $display("FAIL errcnt_sat got=%h exp=ffff", err_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_bad_half();
    test_stall();
    test_jitter();
    test_reset_mid_lock();
`ifdef DIVMON_ERRCNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
